muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with the architectural HI/LO registers, sitting in the execute stage directly downstream of instruction decode. It consumes the decoded ALU function code, hi/lo write flags and register operands for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It supplies HI/LO to MFHI/MFLO. It raises a stall while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_unit_div.sv | 48 ++++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
// Function codes match the decode-stage encodings.
package muldiv_pkg;

   localparam logic [3:0] F_MULT  = 4'b1011;
   localparam logic [3:0] F_MULTU = 4'b1100;
   localparam logic [3:0] F_DIV   = 4'b1101;
   localparam logic [3:0] F_DIVU  = 4'b1110;

   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

endpackage

// File: rtl/muldiv_unit_div.sv
// Restoring divider datapath: one quotient bit per step, MSB first.
// Operands arrive as magnitudes; sign fix-up lives in the top.
module div_restore
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        step,
   input  logic        flush,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [32:0] trial;

   // Borrow out of the 33-bit subtract means the trial failed.
   assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step && !flush) begin
         if (!trial[32]) begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
         end else begin
            rem_q <= {rem_q[30:0], quo_q[31]};
            quo_q <= {quo_q[30:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Stalls the pipeline through busy_o while an operation runs.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid_i,
   input  logic [3:0]  funct_i,
   input  logic        hi_write_i,
   input  logic        lo_write_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
   localparam logic [4:0] DIV_CNT = 5'(DIV_ITER - 1);

   state_t      state;
   logic [4:0]  count;
   logic [31:0] hi, lo;
   logic        done;
   logic [31:0] op_a, op_b;
   logic        msign, q_neg, r_neg, dz;

   logic        is_mul, is_div, sgn_div;
   logic        div_go;
   logic [31:0] abs_a, abs_b;
   logic [31:0] quo, rem;
   logic [31:0] q_fix, r_fix;
   logic signed [63:0] sprod;
   logic [63:0] uprod, prod;

   assign is_mul  = (funct_i == F_MULT) || (funct_i == F_MULTU);
   assign is_div  = (funct_i == F_DIV) || (funct_i == F_DIVU);
   assign sgn_div = (funct_i == F_DIV);

   assign abs_a = (sgn_div && a_i[31]) ? -a_i : a_i;
   assign abs_b = (sgn_div && b_i[31]) ? -b_i : b_i;

   assign div_go = (state == S_IDLE) && valid_i && !flush_i
                   && is_div && (b_i != '0);

   div_restore u_div (
      .clk       (clk),
      .resetn    (resetn),
      .start     (div_go),
      .step      (state == S_DIV),
      .flush     (flush_i),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (quo),
      .remainder (rem)
   );

   assign q_fix = q_neg ? -quo : quo;
   assign r_fix = r_neg ? -rem : rem;

   assign sprod = $signed(op_a) * $signed(op_b);
   assign uprod = op_a * op_b;
   assign prod  = msign ? $unsigned(sprod) : uprod;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         msign <= 1'b0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         dz    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush_i) begin
            state <= S_IDLE;
            count <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (valid_i && is_mul) begin
                     op_a  <= a_i;
                     op_b  <= b_i;
                     msign <= (funct_i == F_MULT);
                     count <= MUL_CNT;
                     state <= S_MUL;
                  end else if (valid_i && is_div) begin
                     // op_a doubles as the forced HI on divide by zero
                     op_a  <= a_i;
                     q_neg <= sgn_div && (a_i[31] ^ b_i[31]);
                     r_neg <= sgn_div && a_i[31];
                     dz    <= (b_i == '0);
                     count <= DIV_CNT;
                     state <= (b_i == '0) ? S_FIX : S_DIV;
                  end else if (valid_i) begin
                     if (hi_write_i) hi <= a_i;
                     if (lo_write_i) lo <= a_i;
                  end
               end
               S_MUL: begin
                  if (count == '0) begin
                     hi    <= prod[63:32];
                     lo    <= prod[31:0];
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     count <= count - 5'd1;
                  end
               end
               S_DIV: begin
                  if (count == '0) state <= S_FIX;
                  else count <= count - 5'd1;
               end
               S_FIX: begin
                  hi    <= dz ? op_a : r_fix;
                  lo    <= dz ? 32'hFFFF_FFFF : q_fix;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_o = (state != S_IDLE);
   assign done_o = done;
   assign hi_o   = hi;
   assign lo_o   = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit.
// Table-driven ops plus flush, MTHI/MTLO and async-reset sequences.
module tb_muldiv_unit;

   localparam logic [3:0] MULT  = 4'b1011;
   localparam logic [3:0] MULTU = 4'b1100;
   localparam logic [3:0] DIV   = 4'b1101;
   localparam logic [3:0] DIVU  = 4'b1110;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [3:0]  funct = '0;
   logic        hi_w = 1'b0;
   logic        lo_w = 1'b0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        flush = 1'b0;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.MUL_LAT(2)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .valid_i    (valid),
      .funct_i    (funct),
      .hi_write_i (hi_w),
      .lo_write_i (lo_w),
      .a_i        (a_in),
      .b_i        (b_in),
      .flush_i    (flush),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   typedef struct {
      logic [3:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int          nb;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t v[10];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] f,
                        input logic hw, input logic lw,
                        input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      valid = 1'b1;
      funct = f;
      hi_w  = hw;
      lo_w  = lw;
      a_in  = a;
      b_in  = b;
      @(posedge clk);
      #1;
      valid = 1'b0;
      funct = '0;
      hi_w  = 1'b0;
      lo_w  = 1'b0;
   endtask

   // Counts busy cycles after issue and done pulses, incl. one extra cycle.
   task automatic wait_done(output int nb, output int nd);
      bit to;
      nb = 0;
      nd = 0;
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_o) nd++;
         if (busy_o) nb++;
         else begin
            to = 1'b0;
            break;
         end
      end
      @(negedge clk);
      if (done_o) nd++;
      checks++;
      if (to) begin
         failures++;
         $display("FAIL timeout: busy_o still high after 200 cycles");
      end
   endtask

   initial begin
      int nb, nd;

      v[0] = '{MULT,  32'hFFFF_FFFE, 32'd3, 2,
               32'hFFFF_FFFF, 32'hFFFF_FFFA};
      v[1] = '{MULTU, 32'hFFFF_FFFE, 32'd3, 2,
               32'h0000_0002, 32'hFFFF_FFFA};
      v[2] = '{DIV,   32'hFFFF_FFF9, 32'd2, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFFD};
      v[3] = '{DIVU,  32'd100, 32'd7, 33, 32'd2, 32'd14};
      v[4] = '{DIVU,  32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF};
      v[5] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33,
               32'h0, 32'h8000_0000};
      v[6] = '{DIV,   32'd7, 32'hFFFF_FFFE, 33,
               32'd1, 32'hFFFF_FFFD};
      v[7] = '{MULT,  32'h8000_0000, 32'h8000_0000, 2,
               32'h4000_0000, 32'h0};
      v[8] = '{DIV,   32'hFFFF_FFF9, 32'd0, 1,
               32'hFFFF_FFF9, 32'hFFFF_FFFF};
      v[9] = '{DIVU,  32'hFFFF_FFFF, 32'd1, 33,
               32'h0, 32'hFFFF_FFFF};

      #12;
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      chk("reset_done", {31'd0, done_o}, 32'd0);
      chk("reset_hi", hi_o, 32'd0);
      chk("reset_lo", lo_o, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         issue(v[i].f, 1'b0, 1'b0, v[i].a, v[i].b);
         wait_done(nb, nd);
         chk($sformatf("v%0d_busy", i), nb, v[i].nb);
         chk($sformatf("v%0d_done", i), nd, 32'd1);
         chk($sformatf("v%0d_hi", i), hi_o, v[i].hi);
         chk($sformatf("v%0d_lo", i), lo_o, v[i].lo);
      end

      // MTHI then MTLO in idle
      issue(4'd0, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
      chk("mthi_hi", hi_o, 32'h1234_5678);
      chk("mthi_busy", {31'd0, busy_o}, 32'd0);
      issue(4'd0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'd0);
      chk("mtlo_lo", lo_o, 32'hCAFE_F00D);
      chk("mtlo_hi", hi_o, 32'h1234_5678);

      // Flush in DIV cycle 10
      issue(DIVU, 1'b0, 1'b0, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_div_busy", {31'd0, busy_o}, 32'd0);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o || busy_o) nd++;
      end
      chk("flush_div_quiet", nd, 32'd0);
      chk("flush_div_hi", hi_o, 32'h1234_5678);
      chk("flush_div_lo", lo_o, 32'hCAFE_F00D);

      // Flush on the issue cycle
      @(negedge clk);
      valid = 1'b1;
      funct = DIV;
      a_in  = 32'd100;
      b_in  = 32'd7;
      flush = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      flush = 1'b0;
      chk("flush_iss_busy", {31'd0, busy_o}, 32'd0);
      nd = 0;
      repeat (5) begin
         @(negedge clk);
         if (done_o || busy_o) nd++;
      end
      chk("flush_iss_quiet", nd, 32'd0);
      chk("flush_iss_lo", lo_o, 32'hCAFE_F00D);

      // MTLO presented while DIV busy is ignored
      issue(DIVU, 1'b0, 1'b0, 32'd100, 32'd7);
      repeat (20) begin
         @(negedge clk);
         valid = 1'b1;
         funct = 4'd0;
         lo_w  = 1'b1;
         a_in  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      valid = 1'b0;
      lo_w  = 1'b0;
      wait_done(nb, nd);
      chk("busy_mtlo_done", nd, 32'd1);
      chk("busy_mtlo_lo", lo_o, 32'd14);
      chk("busy_mtlo_hi", hi_o, 32'd2);

      // Async reset between edges mid-DIV
      issue(DIV, 1'b0, 1'b0, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("areset_busy", {31'd0, busy_o}, 32'd0);
      chk("areset_done", {31'd0, done_o}, 32'd0);
      chk("areset_hi", hi_o, 32'd0);
      chk("areset_lo", lo_o, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      valid  = 1'b1;
      funct  = MULT;
      a_in   = 32'd3;
      b_in   = 32'd5;
      @(posedge clk);
      #1;
      valid = 1'b0;
      funct = '0;
      chk("post_rst_busy", {31'd0, busy_o}, 32'd1);
      wait_done(nb, nd);
      chk("post_rst_done", nd, 32'd1);
      chk("post_rst_hi", hi_o, 32'd0);
      chk("post_rst_lo", lo_o, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
